// File: rtl/pic_rw_ctrl_seq.sv
// pic_rw_ctrl_seq: PIC CPU bus interface. It holds the data-bus buffer and the
// read/write control. Writes are decoded into ICW1..ICW4 during initialisation
// and into OCW1..OCW3 afterwards. Reads return IMR, IRR, ISR or a poll word.
//
// Bus handshake: a write is taken on the rising edge of wr_n. That is the cycle
// where wr_q=0 and wr_n=1 while cs_n=0. d_in and a0 are sampled in that same
// cycle. A read drives d_oe/d_out one cycle after cs_n=0 and rd_n=0 are
// sampled, and stops one cycle after either of them goes high. A read that
// overlaps a write never drives the bus.
module pic_rw_ctrl_seq #(
  parameter int N_IR    = 8,
  parameter int CASCADE = 1,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              a0,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  input  logic [N_IR-1:0]   irr_in,
  input  logic [N_IR-1:0]   isr_in,
  output logic [N_IR-1:0]   imr,
  output logic [4:0]        vec_base,
  output logic              ltim,
  output logic              sngl,
  output logic [7:0]        cas_cfg,
  output logic [4:0]        icw4,
  output logic              ocw2_stb,
  output logic [2:0]        ocw2_cmd,
  output logic [2:0]        ocw2_lvl,
  output logic              smm,
  output logic              ready
);

  if (DATA_W != 8) begin : g_bad_width
    $error("pic_rw_ctrl_seq: DATA_W must be 8");
  end

  // IMPL_MASK has a 1 for each existing IR line; IMR keeps the other bits at 1.
  localparam logic [7:0] IMPL_MASK = 8'((16'd1 << N_IR) - 16'd1);

  typedef enum logic [2:0] {
    S_WAIT_ICW1 = 3'd0,
    S_ICW2      = 3'd1,
    S_ICW3      = 3'd2,
    S_ICW4      = 3'd3,
    S_READY     = 3'd4
  } state_t;

  state_t     state;
  logic       wr_q, rd_q;
  logic       ic4;
  logic       rsel;       // 0: IRR, 1: ISR
  logic       poll_pend;
  logic       poll_rd;    // the read in progress is a poll read
  logic [7:0] imr_r;
  logic [7:0] irr_ext, isr_ext, pend;
  logic [2:0] poll_lvl;
  logic [7:0] rd_data;
  logic       wr_ev, rd_now, poll_done;

  assign imr       = imr_r[N_IR-1:0];
  assign wr_ev     = !cs_n && !wr_q && wr_n;
  assign rd_now    = !cs_n && !rd_n && wr_n;
  assign poll_done = poll_rd && !rd_q && rd_n;

  // Read data select: zero-extended IRR/ISR, a poll word, or IMR.
  // The loop counts down, so the lowest set bit (IR0 highest priority) wins.
  always_comb begin
    irr_ext = '0;
    isr_ext = '0;
    irr_ext[N_IR-1:0] = irr_in;
    isr_ext[N_IR-1:0] = isr_in;
    pend = irr_ext & ~imr_r;
    poll_lvl = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) poll_lvl = 3'(i);
    end
    if (poll_pend)
      rd_data = (pend != 8'h00) ? {1'b1, 4'b0000, poll_lvl} : 8'h00;
    else if (a0)
      rd_data = imr_r;
    else
      rd_data = rsel ? isr_ext : irr_ext;
  end

  // Write decode: ICW1 is accepted from any state, then ICW2..ICW4, then OCWs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT_ICW1;
      wr_q      <= 1'b1;
      ic4       <= 1'b0;
      rsel      <= 1'b0;
      poll_pend <= 1'b0;
      imr_r     <= 8'hFF;
      vec_base  <= 5'd0;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      cas_cfg   <= 8'h00;
      icw4      <= 5'd0;
      ocw2_stb  <= 1'b0;
      ocw2_cmd  <= 3'd0;
      ocw2_lvl  <= 3'd0;
      smm       <= 1'b0;
      ready     <= 1'b0;
    end else begin
      wr_q     <= wr_n;
      ocw2_stb <= 1'b0;
      if (poll_done) poll_pend <= 1'b0;
      if (wr_ev) begin
        if (!a0 && d_in[4]) begin
          ltim     <= d_in[3];
          sngl     <= d_in[1];
          ic4      <= d_in[0];
          imr_r    <= ~IMPL_MASK;
          vec_base <= 5'd0;
          cas_cfg  <= 8'h00;
          icw4     <= 5'd0;
          smm      <= 1'b0;
          rsel     <= 1'b0;
          ready    <= 1'b0;
          state    <= S_ICW2;
        end else begin
          case (state)
            S_ICW2: if (a0) begin
              vec_base <= d_in[7:3];
              if (CASCADE != 0 && !sngl) state <= S_ICW3;
              else if (ic4) state <= S_ICW4;
              else begin
                state <= S_READY;
                ready <= 1'b1;
              end
            end
            S_ICW3: if (a0) begin
              cas_cfg <= d_in;
              if (ic4) state <= S_ICW4;
              else begin
                state <= S_READY;
                ready <= 1'b1;
              end
            end
            S_ICW4: if (a0) begin
              icw4  <= d_in[4:0];
              state <= S_READY;
              ready <= 1'b1;
            end
            S_READY: begin
              if (a0) begin
                imr_r <= d_in | ~IMPL_MASK;
              end else if (!d_in[3]) begin
                ocw2_stb <= 1'b1;
                ocw2_cmd <= d_in[7:5];
                ocw2_lvl <= d_in[2:0];
              end else begin
                if (d_in[1]) rsel <= d_in[0];
                if (d_in[2]) poll_pend <= 1'b1;
                if (d_in[6]) smm <= d_in[5];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read path: register the drive enable and data, and track poll reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b1;
      d_oe    <= 1'b0;
      d_out   <= '0;
      poll_rd <= 1'b0;
    end else begin
      rd_q    <= rd_n;
      d_oe    <= rd_now;
      poll_rd <= rd_now ? poll_pend : 1'b0;
      if (rd_now) d_out <= rd_data;
    end
  end

endmodule
